// File: rtl/alu_seg_scan.sv
// Purpose: latch one ALU result on valid and show it on a 4-digit common-anode seven-segment display (result, op code, flag, sign).
// Latency: capture lands on the valid edge; seg/an are combinational from registered state, so new data shows the next cycle.
// Backpressure: none. valid is never stalled, and every valid edge overwrites the held result.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high, has priority over everything
//   valid      capture strobe; func/sum/cout/overflow/f are latched on each edge with valid=1
//   func       ALU op code (000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 slt, 111 eq)
//   sum        adder result
//   cout       adder carry-out
//   overflow   adder signed overflow; while held set, the result digit blinks
//   f          logic/compare result
//   seg        {dp,g,f,e,d,c,b,a}, active-low
//   an         digit enables, active-low, exactly one bit low
//   frame_done one-cycle pulse after the digit index wraps 3->0
module alu_seg_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [2:0] func,
  input  logic [3:0] sum,
  input  logic       cout,
  input  logic       overflow,
  input  logic [3:0] f,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_O     = 7'h40;
  localparam logic [6:0] GLYPH_C     = 7'h46;

  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic          r_have;
  logic [2:0]    r_func;
  logic [3:0]    r_sum;
  logic          r_cout;
  logic          r_ovf;
  logic [3:0]    r_f;
  logic [BW-1:0] r_bcnt;
  logic          r_bph;
  logic          r_fd;

  logic          w_pre_wrap;
  logic          w_frame_wrap;
  logic          w_is_arith;
  logic [3:0]    w_result;
  logic [6:0]    w_glyph;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign w_pre_wrap   = (r_pre == PRE_LAST);
  assign w_frame_wrap = w_pre_wrap && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_have <= 1'b0;
      r_func <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_f    <= '0;
      r_bcnt <= '0;
      r_bph  <= 1'b0;
      r_fd   <= 1'b0;
    end else begin
      r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
      if (w_pre_wrap) begin
        r_idx <= r_idx + 2'd1;
      end
      r_fd <= w_frame_wrap;

      // A capture restarts the blink so a fresh result always starts visible;
      // it overrides any blink advance from a wrap on the same edge.
      if (valid) begin
        r_have <= 1'b1;
        r_func <= func;
        r_sum  <= sum;
        r_cout <= cout;
        r_ovf  <= overflow;
        r_f    <= f;
        r_bcnt <= '0;
        r_bph  <= 1'b0;
      end else if (!r_ovf) begin
        r_bcnt <= '0;
        r_bph  <= 1'b0;
      end else if (w_frame_wrap) begin
        if (r_bcnt == BLINK_LAST) begin
          r_bcnt <= '0;
          r_bph  <= ~r_bph;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end
    end
  end

  assign w_is_arith = (r_func == 3'b000) || (r_func == 3'b001);
  assign w_result   = w_is_arith ? r_sum : r_f;

  always_comb begin
    w_glyph = GLYPH_BLANK;
    if (r_have) begin
      case (r_idx)
        2'd0: w_glyph = (r_ovf && r_bph) ? GLYPH_BLANK : hex_glyph(w_result);
        2'd1: w_glyph = hex_glyph({1'b0, r_func});
        2'd2: w_glyph = r_ovf ? GLYPH_O : (r_cout ? GLYPH_C : GLYPH_BLANK);
        default: w_glyph = (w_is_arith && r_sum[3]) ? GLYPH_DASH : GLYPH_BLANK;
      endcase
    end
  end

  assign seg        = {1'b1, w_glyph};
  assign an         = ~(4'b0001 << r_idx);
  assign frame_done = r_fd;

endmodule

// File: tb/tb_alu_seg_scan.sv
// Purpose: randomized and directed checking of alu_seg_scan against a cycle-count reference model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: not applicable.
module tb_alu_seg_scan;

  localparam int SD = 4;
  localparam int BD = 2;
  localparam int FR = SD * 4;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [2:0] func;
  logic [3:0] sum;
  logic       cout;
  logic       overflow;
  logic [3:0] f;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;

  alu_seg_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .func       (func),
    .sum        (sum),
    .cout       (cout),
    .overflow   (overflow),
    .f          (f),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: elapsed cycles since reset and frames since last capture.
  int         m_t;
  int         m_frames;
  bit         m_have;
  logic [2:0] m_func;
  logic [3:0] m_sum;
  logic       m_cout;
  logic       m_ovf;
  logic [3:0] m_f;
  bit         m_fd;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  function automatic int m_idx();
    return (m_t / SD) % 4;
  endfunction

  function automatic logic [7:0] m_seg();
    int         i;
    bit         arith;
    bit         ph;
    logic [3:0] r;
    logic [6:0] g;
    i     = m_idx();
    arith = (m_func == 3'd0) || (m_func == 3'd1);
    r     = arith ? m_sum : m_f;
    ph    = m_ovf && (((m_frames / BD) % 2) == 1);
    g     = 7'h7F;
    if (m_have) begin
      if (i == 0)      g = ph ? 7'h7F : hex_tab[r];
      else if (i == 1) g = hex_tab[{1'b0, m_func}];
      else if (i == 2) g = m_ovf ? 7'h40 : (m_cout ? 7'h46 : 7'h7F);
      else             g = (arith && m_sum[3]) ? 7'h3F : 7'h7F;
    end
    return {1'b1, g};
  endfunction

  task automatic tick();
    bit wrap;
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_frames = 0; m_have = 0; m_fd = 0;
      m_func = '0; m_sum = '0; m_cout = 0; m_ovf = 0; m_f = '0;
    end else begin
      wrap = (m_t % FR) == FR - 1;
      m_fd = wrap;
      m_t++;
      if (valid) begin
        m_have = 1; m_func = func; m_sum = sum; m_cout = cout; m_ovf = overflow; m_f = f;
        m_frames = 0;
      end else if (wrap) begin
        m_frames++;
      end
    end
    #1;
    chk("an", an, ~(32'd1 << m_idx()) & 32'hF);
    chk("seg", seg, m_seg());
    chk("frame_done", frame_done, m_fd);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic capture(input logic [2:0] fn, input logic [3:0] s, input logic c,
                         input logic o, input logic [3:0] fv);
    valid = 1; func = fn; sum = s; cout = c; overflow = o; f = fv;
    tick();
    valid = 0; func = $urandom; sum = $urandom; cout = $urandom; overflow = $urandom; f = $urandom;
  endtask

  // One full frame, comparing every digit with constants.
  task automatic check_digits(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] e [4];
    e[0] = d0; e[1] = d1; e[2] = d2; e[3] = d3;
    for (int k = 0; k < FR; k++) begin
      tick();
      chk($sformatf("%s_idx%0d", tag, m_idx()), seg, e[m_idx()]);
    end
  endtask

  initial begin
    rst = 1; valid = 0; func = 0; sum = 0; cout = 0; overflow = 0; f = 0;
    m_t = 0; m_frames = 0; m_have = 0; m_fd = 0;
    m_func = '0; m_sum = '0; m_cout = 0; m_ovf = 0; m_f = '0;
    run(2);
    chk("reset_an", an, 4'b1110);
    chk("reset_seg", seg, 8'hFF);
    chk("reset_fd", frame_done, 1'b0);
    rst = 0;
    run(40);

    // Overflowed add: '9', '0', 'O', '-', then blink over 64 cycles.
    capture(3'b000, 4'h9, 1'b1, 1'b1, 4'h0);
    check_digits("add_ovf", 8'h90, 8'hC0, 8'hC0, 8'hBF);
    run(64);

    // AND result with carry, no overflow: steady display.
    capture(3'b011, 4'h3, 1'b1, 1'b0, 4'hA);
    check_digits("and_c", 8'h88, 8'hB0, 8'hC6, 8'hFF);
    run(48);

    // Capture on the 3->0 wrap edge while the result digit is blanked.
    capture(3'b000, 4'h9, 1'b1, 1'b1, 4'h0);
    for (int k = 0; k < 4 * FR && m_frames < BD; k++) tick();
    chk("blink_reached", m_frames >= BD, 1'b1);
    for (int k = 0; k < FR && (m_t % FR) != FR - 1; k++) tick();
    capture(3'b000, 4'h9, 1'b1, 1'b1, 4'h0);
    chk("wrapcap_fd", frame_done, 1'b1);
    chk("wrapcap_an", an, 4'b1110);
    chk("wrapcap_seg", seg, 8'h90);
    run(20);

    // Reset in the middle of a frame on digit 2.
    for (int k = 0; k < FR && m_idx() != 2; k++) tick();
    chk("mid_idx2", an, 4'b1011);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_an", an, 4'b1110);
    chk("midrst_seg", seg, 8'hFF);
    capture(3'b010, 4'h0, 1'b0, 1'b0, 4'h5);
    chk("not5_seg", seg, 8'h92);
    run(20);

    // Randomized traffic with occasional resets and back-to-back captures.
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 299) == 0);
      valid    = ($urandom_range(0, 19) == 0);
      func     = $urandom;
      sum      = $urandom;
      cout     = $urandom;
      overflow = ($urandom_range(0, 1) == 0);
      f        = $urandom;
      tick();
    end
    rst = 0; valid = 0;
    run(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seg_scan.md
Name: alu_seg_scan

Overview:
Downstream display stage for the 4-bit switch-driven ALU. It captures one ALU result (func, sum, cout, overflow, f) on a valid strobe and holds it. It drives a 4-digit, common-anode, time-multiplexed seven-segment display with the result, the op code, a flag glyph and a sign marker. While a captured result has overflow set, the result digit blinks.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot; must be >= 2
BLINK_DIV, 64, full scan frames per blink half-period; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
valid  in  1  capture strobe; inputs are latched on every rising clk edge where valid=1
func  in  3  ALU op code (000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 slt, 111 eq)
sum  in  4  adder result
cout  in  1  adder carry-out
overflow  in  1  adder signed overflow
f  in  4  logic/compare result
seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
an  out  4  digit enables, active-low, one-hot-zero (exactly one bit 0)
frame_done  out  1  one-cycle pulse when the digit index wraps 3->0

Behaviour:
- All state updates on the rising clk edge. rst has priority over valid and all counters.
- Reset state: prescaler=0, idx=0, have_data=0, captured regs=0, blink_cnt=0, blink_ph=0, frame_done=0. Resulting outputs: an=4'b1110, seg=8'hFF.
- Capture: valid=1 latches func/sum/cout/overflow/f and sets have_data=1. The same edge clears blink_cnt and blink_ph.
  - Holding valid high recaptures every cycle.
  - Inputs are ignored while valid=0.
- Latency: seg and an are combinational from registered state. New data is visible in the cycle after the capture edge.
- Prescaler: counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and idx advances (3 wraps to 0).
- frame_done is registered: it is 1 for exactly one cycle following the edge where idx goes 3->0.
- an = ~(4'b0001 << idx). dp (seg[7]) is always 1.
- Displayed result R: sum when func is 000 or 001; f otherwise.
- Digit glyphs when have_data=1:
  - idx0: hex(R). Shows blank instead when the captured overflow=1 and blink_ph=1.
  - idx1: hex({1'b0,func}).
  - idx2: 'O' if overflow, else 'C' if cout, else blank. Overflow has priority.
  - idx3: '-' if func is 000/001 and sum[3]=1, else blank.
- have_data=0: every digit is blank.
- Glyph codes for seg[6:0] (g..a):
  - Hex 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
  - Blank 7F, '-' 3F, 'O' 40, 'C' 46.
- Blink: runs only when the captured overflow=1.
  - blink_cnt advances on each frame_done-generating wrap.
  - At BLINK_DIV-1 it wraps and toggles blink_ph.
  - When captured overflow=0, blink_cnt and blink_ph are held at 0.
- Simultaneous capture and idx wrap: the idx wrap and frame_done proceed normally. The blink clear from the capture wins over the blink advance.
- Reset mid-frame or mid-blink returns to the reset state in the next cycle. The display goes blank.
- Counter widths: prescaler is clog2(SCAN_DIV) bits, blink_cnt is max(1,clog2(BLINK_DIV)) bits, idx is 2 bits. All wrap only as specified.

Test Plan (SCAN_DIV=4, BLINK_DIV=2 unless noted):
- Reset, no valid, run 40 cycles -> seg=8'hFF throughout. an cycles 1110,1101,1011,0111, changing every 4 cycles. frame_done pulses every 16 cycles.
- valid pulse with func=000, sum=4'h9, cout=1, overflow=1 -> digits: idx0 seg 8'h90 ('9'), idx1 8'hC0 ('0'), idx2 8'hC0 ('O'), idx3 8'hBF ('-').
- Same capture, observe 64 cycles -> idx0 alternates '9' (8'h90) / blank (8'hFF) every 2 frames. Other digits are steady.
- valid with func=011, f=4'hA, sum=4'h3, cout=1, overflow=0 -> idx0 8'h88 ('A'), idx1 8'hB0 ('3'), idx2 8'hC6 ('C'), idx3 8'hFF. No blinking.
- valid asserted on the same edge as the idx 3->0 wrap while blinking -> frame_done still pulses. blink_ph=0 on the next cycle, so idx0 is visible.
- rst asserted mid-frame with idx=2 and data held -> next cycle an=4'b1110, seg=8'hFF. A later valid with func=010, f=4'h5 shows '5' on idx0.
